// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one combinational unsigned
// divider among NREQ valid/ready requesters and returns a tagged, registered
// response two cycles after each grant.
// Optional feature macro: DIV_ERR_CHECK_EN (overflow / divide-by-zero flagging
// with saturated quotient). Without it rsp_err is always 0 and raw results pass.

// Combinational restoring divider producing an (M-N+1)-bit quotient. Results are
// only meaningful when the quotient fits, i.e. (a >> (M-N+1)) < b.
module divider #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic [M-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [M-N:0] q_o
);
    logic [N-1:0] part;
    logic [N:0]   trial;

    // One restoring step per quotient bit, MSB first; the partial remainder is
    // seeded with the top N-1 dividend bits.
    always_comb begin
        q_o   = '0;
        part  = N'(a_i[M-1:M-N+1]);
        trial = '0;
        for (int i = M - N; i >= 0; i--) begin
            trial = {part, a_i[i]};
            if (trial >= {1'b0, b_i}) begin
                q_o[i] = 1'b1;
                trial  = trial - {1'b0, b_i};
            end
            part = trial[N-1:0];
        end
    end
endmodule

module div_arbiter #(
    parameter int M    = 8,
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*M-1:0]  req_a,
    input  logic [NREQ*N-1:0]  req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [M-N:0]       rsp_q,
    output logic [N-1:0]       rsp_r,
    output logic               rsp_err
);
    localparam int QW = M - N + 1;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [M-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic [QW-1:0]  quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           err_q, err_d;

    logic [M-1:0]   a_arr [NREQ];
    logic [N-1:0]   b_arr [NREQ];
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic [QW-1:0]  div_q;
    logic [N-1:0]   rem_calc;

    // Unpack the flat operand buses into per-requester lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_arr[gi] = req_a[gi*M +: M];
            assign b_arr[gi] = req_b[gi*N +: N];
        end
    endgenerate

    divider #(.M(M), .N(N)) u_divider (
        .a_i (a_q),
        .b_i (b_q),
        .q_o (div_q)
    );

    // Remainder derived from the quotient at dividend width, then truncated.
    assign rem_calc = N'(a_q - M'(div_q) * M'(b_q));

`ifdef DIV_ERR_CHECK_EN
    logic ovf;
    // Quotient overflows its QW bits unless (A >> QW) < B; B==0 always trips this.
    assign ovf = (a_q >> QW) >= M'(b_q);
`endif

    // Round-robin pick: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state, grant and datapath-capture logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d     = a_arr[grant_idx];
                    b_d     = b_arr[grant_idx];
                    id_d    = grant_idx;
                    ptr_d   = IDW'((int'(grant_idx) + 1) % NREQ);
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef DIV_ERR_CHECK_EN
                if (ovf) begin
                    quo_d = '1;
                    rem_d = '0;
                    err_d = 1'b1;
                end else begin
                    quo_d = div_q;
                    rem_d = rem_calc;
                    err_d = 1'b0;
                end
`else
                quo_d = div_q;
                rem_d = rem_calc;
                err_d = 1'b0;
`endif
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = id_q;
    assign rsp_q     = quo_q;
    assign rsp_r     = rem_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: expected responses are pushed when a request
// handshake is observed and popped when the response handshakes.
module tb_div_arbiter;
    localparam int M    = 8;
    localparam int N    = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int QW   = M - N + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*M-1:0]  req_a;
    logic [NREQ*N-1:0]  req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [QW-1:0]      rsp_q;
    logic [N-1:0]       rsp_r;
    logic               rsp_err;

    div_arbiter #(.M(M), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int q;
        int r;
        int err;
        bit chk_qr;
        int due;
    } exp_t;

    exp_t sb[$];
    int   grant_id[$];
    int   grant_cyc[$];
    int   last_hs_cyc = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour of one division, independent of the divider structure.
    function automatic exp_t model(input int id, input int a, input int b, input int due);
        exp_t e;
        e.id  = id;
        e.due = due;
        if (b == 0 || (a >> QW) >= b) begin
`ifdef DIV_ERR_CHECK_EN
            e.err = 1; e.q = (1 << QW) - 1; e.r = 0; e.chk_qr = 1'b1;
`else
            e.err = 0; e.q = 0; e.r = 0; e.chk_qr = 1'b0;
`endif
        end else begin
            e.err = 0; e.q = a / b; e.r = a % b; e.chk_qr = 1'b1;
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [11:0] prev_pack;
        logic [11:0] cur_pack;
        exp_t        e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_pack  = '0;
        forever begin
            @(negedge clk);
            cur_pack = {rsp_id, rsp_q, rsp_r, rsp_err};
            if (rst) begin
                sb.delete();
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (req_ready != '0)
                    check_val("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        grant_id.push_back(i);
                        grant_cyc.push_back(cyc);
                        sb.push_back(model(i, int'(req_a[i*M +: M]), int'(req_b[i*N +: N]), cyc + 2));
                        $display("grant id=%0d a=%0d b=%0d cycle=%0d", i, req_a[i*M +: M], req_b[i*N +: N], cyc);
                    end
                end
                if (rsp_valid && !prev_valid) begin
                    if (sb.size() == 0) check_val("unexpected_rsp", 1, 0);
                    else check_val("latency", cyc, sb[0].due);
                end
                if (rsp_valid && prev_valid && !prev_ready)
                    check_val("hold_stable", int'(cur_pack), int'(prev_pack));
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check_val("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("rsp id=%0d q=%0d r=%0d err=%0d cycle=%0d", rsp_id, rsp_q, rsp_r, rsp_err, cyc);
                        check_val("rsp_id", int'(rsp_id), e.id);
                        if (e.chk_qr) begin
                            check_val("rsp_q", int'(rsp_q), e.q);
                            check_val("rsp_r", int'(rsp_r), e.r);
                        end
                        check_val("rsp_err", int'(rsp_err), e.err);
                    end
                    last_hs_cyc = cyc;
                end
                prev_valid = rsp_valid;
                prev_ready = rsp_ready;
                prev_pack  = cur_pack;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]     = 1'b1;
        req_a[i*M +: M]  = M'(a);
        req_b[i*N +: N]  = N'(b);
    endtask

    task automatic clear_log();
        grant_id.delete();
        grant_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (grant_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (grant_id.size() < n) check_val("grant_timeout", grant_id.size(), n);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < budget) begin
            tick();
            k++;
        end
        if (sb.size() != 0 || rsp_valid) check_val("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int c0;
        int k;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_val("reset_rsp_valid", int'(rsp_valid), 0);
        check_val("reset_req_ready", int'(req_ready), 0);
        check_val("reset_rsp_id", int'(rsp_id), 0);
        check_val("reset_rsp_q", int'(rsp_q), 0);
        check_val("reset_rsp_r", int'(rsp_r), 0);
        check_val("reset_rsp_err", int'(rsp_err), 0);
        rst = 1'b0;
        clear_log();

        // Basic divide: 100/7 -> q=14 r=2, granted in the first cycle
        c0 = cyc;
        set_req(0, 100, 7);
        wait_grants(1, 10);
        req_valid = '0;
        if (grant_id.size() >= 1) begin
            check_val("basic_grant_id", grant_id[0], 0);
            check_val("basic_grant_cycle", grant_cyc[0], c0);
        end
        wait_drain(20);

        // Round-robin from ptr=0 with all four requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 60 + 40 * i, 9 + i);
        wait_grants(5, 40);
        req_valid = '0;
        if (grant_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_val("rr_order", grant_id[i], i % NREQ);
            for (int i = 1; i < 5; i++) check_val("rr_interval", grant_cyc[i] - grant_cyc[i-1], 3);
        end
        wait_drain(20);

        // Back-pressure: requester 2, 255/15 -> 17 r 0, held for 5 cycles
        clear_log();
        rsp_ready = 1'b0;
        set_req(2, 255, 15);
        wait_grants(1, 10);
        req_valid = '0;
        set_req(0, 10, 3);
        set_req(1, 20, 3);
        k = 0;
        while (!rsp_valid && k < 10) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check_val("bp_rsp_valid", int'(rsp_valid), 1);
            check_val("bp_req_ready", int'(req_ready), 0);
            check_val("bp_rsp_q", int'(rsp_q), 17);
            check_val("bp_rsp_r", int'(rsp_r), 0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_grants(2, 10);
        req_valid = '0;
        if (grant_id.size() >= 2) begin
            check_val("bp_next_id", grant_id[1], 0);
            check_val("bp_next_gap", grant_cyc[1] - last_hs_cyc, 1);
        end
        wait_drain(20);

        // Overflow and divide-by-zero
        set_req(0, 200, 3);
        wait_grants(grant_id.size() + 1, 10);
        req_valid = '0;
        wait_drain(20);
        set_req(0, 50, 0);
        wait_grants(grant_id.size() + 1, 10);
        req_valid = '0;
        wait_drain(20);

        // Reset during CALC discards the operation and clears ptr
        do_reset();
        set_req(1, 90, 7);
        wait_grants(1, 10);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check_val("rst_mid_valid", int'(rsp_valid), 0);
        tick();
        check_val("rst_mid_q", int'(rsp_q), 0);
        check_val("rst_mid_id", int'(rsp_id), 0);
        tick();
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            check_val("rst_no_rsp", int'(rsp_valid), 0);
            tick();
        end
        set_req(1, 33, 4);
        set_req(3, 44, 5);
        wait_grants(1, 10);
        req_valid = '0;
        if (grant_id.size() >= 1) check_val("rst_first_grant", grant_id[0], 1);
        wait_drain(20);

        // Sparse requests: each granted in its first valid IDLE cycle
        clear_log();
        c0 = cyc;
        set_req(3, 77, 5);
        wait_grants(1, 10);
        req_valid = '0;
        if (grant_id.size() >= 1) begin
            check_val("sparse3_id", grant_id[0], 3);
            check_val("sparse3_cycle", grant_cyc[0], c0);
        end
        wait_drain(20);
        c0 = cyc;
        set_req(1, 45, 6);
        wait_grants(2, 10);
        req_valid = '0;
        if (grant_id.size() >= 2) begin
            check_val("sparse1_id", grant_id[1], 1);
            check_val("sparse1_cycle", grant_cyc[1], c0);
        end
        wait_drain(20);
        set_req(0, 12, 5);
        set_req(2, 99, 9);
        wait_grants(3, 10);
        req_valid = '0;
        if (grant_id.size() >= 3) check_val("sparse_ptr_id", grant_id[2], 2);
        wait_drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one instance of the team's combinational unsigned `divider` between `NREQ` requesters. Each requester sees a valid/ready request port. The block grants requesters round-robin and registers the winner's operands. It computes quotient and remainder across one dedicated settle cycle, then returns a tagged, registered response on a single valid/ready response port. It sits between the integer-datapath clients and the shared divide resource.

## Interface
- `M`, default 8: dividend width; passed to the `divider` instance.
- `N`, default 4: divisor width; passed to the `divider` instance.
- `NREQ`, default 4: number of requesters, minimum 2.
- `IDW`, default 2: requester-ID width, equal to clog2(`NREQ`).

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*M: dividends; requester i uses bits [i*M +: M].
- `req_b`  in  NREQ*N: divisors; requester i uses bits [i*N +: N].
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  IDW: index of the requester that owns the response.
- `rsp_q`  out  M-N+1: quotient.
- `rsp_r`  out  N: remainder.
- `rsp_err`  out  1: divide-by-zero or quotient-overflow flag.

## Operation
- The FSM has three states: IDLE, CALC and HOLD.
- **IDLE**
  - If any `req_valid` bit is high, grant index g.
  - g is the first set bit at or after `ptr`, searching upward and wrapping modulo `NREQ`.
  - Drive `req_ready[g]`=1 combinationally; every other `req_ready` bit is 0.
  - At the clock edge: capture `req_a[g]`, `req_b[g]` and g, set `ptr` to (g+1) mod `NREQ`, and go to CALC.
  - If no `req_valid` bit is high, stay in IDLE.
- **CALC**
  - `req_ready` is all zero.
  - The registered operands drive the `divider` instance.
  - The remainder is computed as (A − Q·B), evaluated at M bits and truncated to N bits.
  - At the edge: register Q, R and the error flag, and go to HOLD.
- **HOLD**
  - `rsp_valid`=1; `req_ready` is all zero.
  - `rsp_id`, `rsp_q`, `rsp_r` and `rsp_err` are held stable until `rsp_valid`&`rsp_ready`.
  - On that handshake, go to IDLE.
  - There is no accept in the same cycle as the handshake.
- **Overflow:** the quotient fits in M-N+1 bits only when (A >> (M-N+1)) < B. B==0 always counts as overflow.
- **Fairness:** `ptr` advances only on a grant. A requester that drops `req_valid` before it is granted loses nothing.
- **Reset (at any time):**
  - state goes to IDLE, `ptr`=0 and `rsp_valid`=0;
  - `rsp_id`, `rsp_q`, `rsp_r` and `rsp_err` go to 0;
  - any in-flight operation is discarded and no response is produced.

## Timing
- The request handshake completes in the IDLE cycle t where `req_valid[g]`&`req_ready[g]`.
- `rsp_valid` rises in cycle t+2, so fixed latency is 2 cycles.
- Minimum issue interval is 3 cycles, reached when `rsp_ready` is held high.
- Response back-pressure stalls the block indefinitely in HOLD. Outputs hold and no new grant is made.
- `req_ready` depends combinationally on `req_valid` and `ptr` only, never on `rsp_ready`.
- Requesters must hold `req_a`/`req_b` stable only in the handshake cycle.

## Configuration
- Macro: `DIV_ERR_CHECK_EN`.
- **Defined:**
  - `rsp_err`=1 when an operation overflows, including B==0.
  - On error, `rsp_q` is forced to all-ones and `rsp_r` to 0.
  - Non-error operations return the divider results.
- **Undefined:**
  - `rsp_err` is tied to 0 and the overflow comparator is removed.
  - `rsp_q` and `rsp_r` always carry the raw divider result and computed remainder, including values that are meaningless on overflow.

## Test plan
All scenarios use defaults: M=8, N=4, NREQ=4.
- **Basic divide.** Requester 0 sends A=100, B=7, with `rsp_ready` high → `req_ready[0]` in cycle t; `rsp_valid` at t+2 with `rsp_id`=0, `rsp_q`=14, `rsp_r`=2, `rsp_err`=0. The block is back in IDLE at t+3.
- **Round-robin.** All four `req_valid` bits held high with fixed operands → grant order 0,1,2,3,0, one grant every 3 cycles. Each `rsp_id` matches its grant, and each Q/R pair is correct for its requester.
- **Back-pressure.** Requester 2 sends A=255, B=15 while `rsp_ready` is low for 5 cycles → `rsp_valid` held, with `rsp_q`=17 and `rsp_r`=0 stable. `req_ready` stays 0 even with other requests pending; the next grant comes only after the handshake.
- **Errors, macro defined.**
  - A=200, B=3 → `rsp_err`=1, `rsp_q`=31, `rsp_r`=0.
  - A=50, B=0 → `rsp_err`=1, `rsp_q`=31, `rsp_r`=0.
  - Macro undefined, A=200, B=3 → `rsp_err`=0.
- **Reset mid-operation.** Assert `rst` during CALC after a grant to requester 1 → `rsp_valid` stays 0 and no response appears. After release, `ptr`=0: with requesters 1 and 3 both valid, requester 1 is granted first.
- **Sparse and toggling requests.** Requester 3 alone, then requester 1 alone → each is granted in its first valid IDLE cycle. After the grant to 3, `ptr` wraps to 0.
